neuron_update_scheduler: RTL and testbench

NEURON_UPDATE_SCHEDULER -- requirements
Module: neuron_update_scheduler

---
 rtl/neuron_update_scheduler.sv | 125 ++++++++++++
 tb/tb_neuron_update_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_update_scheduler.sv
// Time-step sweep scheduler: read, integrate and write back each neuron
// potential, emitting a spike handshake when the threshold is crossed.
module neuron_update_scheduler #(
    parameter int NEURONS = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       v_threshold,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       syn_current,
    output logic              spike_valid,
    output logic [ADDR_W-1:0] spike_id,
    input  logic              spike_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_UPDATE,
        S_WRITE,
        S_SPIKE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NEURONS - 1);

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] index;
    logic [31:0]       thr_q;
    logic [31:0]       pot_q;
    logic [31:0]       wdata_q;
    logic              spiked_q;

    logic              rd;
    logic              wr;
    logic              sv;
    logic              dn;
    logic              adv;
    logic              last;
    logic [31:0]       sum;
    logic              fire;

    assign last = (index == LAST);
    assign sum  = pot_q + syn_current;
    assign fire = ($signed(sum) >= $signed(thr_q));

    always_comb begin
        next = state;
        rd   = 1'b0;
        wr   = 1'b0;
        sv   = 1'b0;
        dn   = 1'b0;
        adv  = 1'b0;
        unique case (state)
            S_IDLE:   if (start) next = S_READ;
            S_READ: begin
                rd   = 1'b1;
                next = S_WAIT;
            end
            S_WAIT:   next = S_UPDATE;
            S_UPDATE: next = S_WRITE;
            S_WRITE: begin
                wr = 1'b1;
                if (spiked_q) next = S_SPIKE;
                else          adv  = 1'b1;
            end
            S_SPIKE: begin
                sv = 1'b1;
                if (spike_ready) adv = 1'b1;
            end
            default:  next = S_IDLE;
        endcase
        // Leaving the last neuron finishes the sweep in the same cycle.
        if (adv) begin
            if (last) begin
                next = S_IDLE;
                dn   = 1'b1;
            end else begin
                next = S_READ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            index    <= '0;
            thr_q    <= '0;
            pot_q    <= '0;
            wdata_q  <= '0;
            spiked_q <= 1'b0;
        end else begin
            state <= next;
            if (state == S_IDLE && start) begin
                thr_q <= v_threshold;
                index <= '0;
            end
            if (state == S_WAIT) pot_q <= mem_rd_data;
            if (state == S_UPDATE) begin
                spiked_q <= fire;
                wdata_q  <= fire ? sum - thr_q : sum;
            end
            if (adv) index <= last ? '0 : index + 1'b1;
        end
    end

    assign mem_rd_en   = rd;
    assign mem_wr_en   = wr;
    assign mem_addr    = index;
    assign mem_wr_data = wdata_q;
    assign spike_valid = sv;
    assign spike_id    = sv ? index : '0;
    assign busy        = (state != S_IDLE);
    assign done        = dn;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Randomised and directed sweeps checked against a per-neuron
// integrate-and-fire reference model with a behavioural memory.
module tb_neuron_update_scheduler;

    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          spike_ready = 1'b1;
    logic [31:0]   v_threshold = '0;
    logic [31:0]   mem_rd_data;
    logic [31:0]   mem_wr_data;
    logic [31:0]   syn_current;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic          spike_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] spike_id;

    logic [31:0] mem  [N];
    logic [31:0] syn  [N];
    logic [31:0] snap [N];
    logic [31:0] expm [N];
    int          exp_sp[$];

    logic [AW+31:0] wr_q[$];
    int             sp_q[$];
    int             done_cnt = 0;
    int             done_cyc = 0;
    int             sp_cycles = 0;
    int             cyc = 0;
    int             n_chk = 0;
    int             n_fail = 0;

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [AW-1:0] pid = '0;

    neuron_update_scheduler #(.NEURONS(N), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .v_threshold (v_threshold),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_data (mem_wr_data),
        .syn_current (syn_current),
        .spike_valid (spike_valid),
        .spike_id    (spike_id),
        .spike_ready (spike_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign syn_current = syn[mem_addr];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            chk("rd_wr_excl", 64'(mem_rd_en & mem_wr_en), 64'd0);
            if (mem_wr_en) wr_q.push_back({mem_addr, mem_wr_data});
            if (spike_valid) begin
                sp_cycles++;
                chk("spike_no_mem", 64'(mem_rd_en | mem_wr_en), 64'd0);
                if (spike_ready) sp_q.push_back(int'(spike_id));
            end
            if (pv && !pr) begin
                chk("spike_hold_v", 64'(spike_valid), 64'd1);
                chk("spike_hold_id", 64'(spike_id), 64'(pid));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        pv  = spike_valid;
        pr  = spike_ready;
        pid = spike_id;
    end

    // Reference: integrate, compare against the threshold, subtract on fire.
    task automatic model(input logic [31:0] thr);
        logic [31:0] s;
        exp_sp.delete();
        for (int i = 0; i < N; i++) begin
            snap[i] = mem[i];
            s = mem[i] + syn[i];
            if ($signed(s) >= $signed(thr)) begin
                expm[i] = s - thr;
                exp_sp.push_back(i);
            end else begin
                expm[i] = s;
            end
        end
    endtask

    task automatic load(input int sel, input logic [31:0] v);
        mem[sel] <= v;
    endtask

    task automatic run_sweep(input logic [31:0] thr, input int rmode,
                             input bit noise, input string nm,
                             output int lat);
        int  st;
        int  hold;
        int  nsp;
        int  exp_lat;
        bit  finished;
        @(negedge clk);
        model(thr);
        nsp = exp_sp.size();
        wr_q.delete();
        sp_q.delete();
        done_cnt  = 0;
        sp_cycles = 0;
        hold      = 0;
        finished  = 0;
        start       = 1'b1;
        v_threshold = thr;
        spike_ready = 1'b1;
        st          = cyc;
        for (int k = 0; k < 400 && !finished; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (noise && k == 6) begin
                start       = 1'b1;
                v_threshold = ~thr;
            end
            case (rmode)
                1: spike_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (spike_valid && hold < 5) begin
                        spike_ready = 1'b0;
                        hold++;
                    end else begin
                        spike_ready = 1'b1;
                    end
                end
                default: spike_ready = 1'b1;
            endcase
            #1;
            if (done) begin
                finished = 1;
                if (noise) start = 1'b1;
            end
        end
        if (!finished) chk({nm, " timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        start       = 1'b0;
        spike_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        lat = done_cyc - st;
        chk({nm, " done_cnt"}, 64'(done_cnt), 64'd1);
        chk({nm, " busy_end"}, 64'(busy), 64'd0);
        chk({nm, " n_writes"}, 64'(wr_q.size()), 64'(N));
        for (int i = 0; i < N && i < wr_q.size(); i++) begin
            chk({nm, " wr_addr"}, 64'(wr_q[i][AW+31:32]), 64'(i));
            chk({nm, " wr_data"}, 64'(wr_q[i][31:0]), 64'(expm[i]));
        end
        chk({nm, " n_spikes"}, 64'(sp_q.size()), 64'(nsp));
        for (int i = 0; i < nsp && i < sp_q.size(); i++)
            chk({nm, " spike_id"}, 64'(sp_q[i]), 64'(exp_sp[i]));
        case (rmode)
            1:       exp_lat = 4 * N + sp_cycles;
            2:       exp_lat = 4 * N + nsp + ((nsp > 0) ? 5 : 0);
            default: exp_lat = 4 * N + nsp;
        endcase
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({nm, " wr_en"}, 64'(mem_wr_en), 64'd0);
        chk({nm, " addr"}, 64'(mem_addr), 64'd0);
        chk({nm, " wr_data"}, 64'(mem_wr_data), 64'd0);
        chk({nm, " spike_v"}, 64'(spike_valid), 64'd0);
        chk({nm, " spike_id"}, 64'(spike_id), 64'd0);
        chk({nm, " busy"}, 64'(busy), 64'd0);
        chk({nm, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  found;
        logic [31:0] thr;
        for (int i = 0; i < N; i++) begin
            load(i, 32'd0);
            syn[i] = 32'd10;
        end
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_sweep(32'd100, 0, 0, "basic", lat);
        chk("basic lat16", 64'(lat), 64'd16);
        for (int i = 0; i < N; i++)
            chk("basic mem10", 64'(mem[i]), 64'd10);

        for (int i = 0; i < N; i++) load(i, 32'd0);
        load(2, 32'd95);
        run_sweep(32'd100, 0, 0, "spike", lat);
        chk("spike mem2", 64'(mem[2]), 64'd5);

        for (int i = 0; i < N; i++) load(i, 32'd0);
        load(2, 32'd95);
        run_sweep(32'd100, 2, 0, "stall", lat);
        chk("stall lat22", 64'(lat), 64'd22);

        for (int i = 0; i < N; i++) begin
            load(i, 32'd0);
            syn[i] = 32'h20;
        end
        load(1, 32'h7FFF_FFF0);
        run_sweep(32'd100, 0, 0, "wrap", lat);
        chk("wrap mem1", 64'(mem[1]), 64'h8000_0010);

        for (int i = 0; i < N; i++) begin
            load(i, 32'd90 + 32'(i));
            syn[i] = 32'd8;
        end
        run_sweep(32'd100, 0, 1, "noise", lat);

        for (int i = 0; i < N; i++) begin
            load(i, 32'($urandom_range(0, 150)));
            syn[i] = 32'd5;
        end
        spike_ready = 1'b1;
        @(negedge clk);
        thr = 32'd80;
        model(thr);
        start       = 1'b1;
        v_threshold = thr;
        found       = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_wr_en && mem_addr == AW'(1)) found = 1;
        end
        chk("rst found_wr1", 64'(found), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("rst mem1_kept", 64'(mem[1]), 64'(snap[1]));
        chk("rst mem0_done", 64'(mem[0]), 64'(expm[0]));
        run_sweep(thr, 0, 0, "after_rst", lat);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    load(i, $urandom);
                    syn[i] = $urandom;
                end else begin
                    load(i, 32'($urandom_range(0, 300)) - 32'd100);
                    syn[i] = 32'($urandom_range(0, 120)) - 32'd20;
                end
            end
            thr = 32'($urandom_range(50, 250));
            run_sweep(thr, int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), "rand", lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
